// File: rtl/scurve_pkg.sv
// scurve_pkg: frame constants and packer state type shared by the S-curve frame packer files
package scurve_pkg;
  localparam logic [15:0] HEADER = 16'hFF45;
  localparam logic [15:0] TRAILER = 16'hFF4E;
  localparam int N_WORDS = 6;
  localparam int FRAME_LEN = 10;
  typedef enum logic [1:0] {COLLECT = 2'd0, SEND = 2'd1} state_t;
endpackage

// File: rtl/scurve_frame_packer_if.sv
// scurve_frame_packer_if: engine-side data/done/id inputs and USB-FIFO/status outputs; master drives the engine side, slave is the packer
interface scurve_frame_packer_if;
  logic [15:0] SCurve_Data;
  logic SCurve_Data_wr_en;
  logic One_Channel_Done;
  logic [5:0] Channel_Index;
  logic [9:0] DAC_Code;
  logic Out_Fifo_Full;
  logic [15:0] Out_Data;
  logic Out_Data_wr_en;
  logic Packer_Busy;
  logic Overflow_Err;
  logic Count_Err;
  modport master (
    output SCurve_Data, SCurve_Data_wr_en, One_Channel_Done, Channel_Index, DAC_Code, Out_Fifo_Full,
    input Out_Data, Out_Data_wr_en, Packer_Busy, Overflow_Err, Count_Err
  );
  modport slave (
    input SCurve_Data, SCurve_Data_wr_en, One_Channel_Done, Channel_Index, DAC_Code, Out_Fifo_Full,
    output Out_Data, Out_Data_wr_en, Packer_Busy, Overflow_Err, Count_Err
  );
endinterface

// File: rtl/scurve_word_buffer.sv
// scurve_word_buffer: 6x16 word store (i_we/i_waddr/i_wdata write, i_raddr/o_rdata read) with running XOR o_xor restarted at address 0
module scurve_word_buffer
  import scurve_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_we,
  input  logic [2:0]  i_waddr,
  input  logic [15:0] i_wdata,
  input  logic [2:0]  i_raddr,
  output logic [15:0] o_rdata,
  output logic [15:0] o_xor
);
  logic [15:0] r_mem [N_WORDS];
  logic [15:0] r_xor;
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
      r_xor <= (i_waddr == 3'd0 ? 16'h0000 : r_xor) ^ i_wdata;
    end
  end
  assign o_rdata = i_raddr < 3'(N_WORDS) ? r_mem[i_raddr] : 16'h0000;
  assign o_xor = r_xor;
endmodule

// File: rtl/scurve_frame_packer.sv
// scurve_frame_packer: collects six S-curve words per channel and emits a HEADER/id/data/chk/TRAILER frame to the USB FIFO (Clk, reset_n, bus)
module scurve_frame_packer
  import scurve_pkg::*;
(
  input logic Clk,
  input logic reset_n,
  scurve_frame_packer_if.slave bus
);
  state_t r_state;
  logic [2:0] r_count;
  logic [3:0] r_idx;
  logic [15:0] r_id, r_out;
  logic r_wr, r_busy, r_ovf, r_cerr;
  logic w_store;
  logic [2:0] w_cnt_next;
  logic [15:0] w_rdata, w_xor, w_word;
  assign w_store = r_state == COLLECT && bus.SCurve_Data_wr_en && r_count < 3'(N_WORDS);
  assign w_cnt_next = r_count + 3'(w_store);
  always_comb w_word = r_idx == 4'd0 ? HEADER :
                       r_idx == 4'd1 ? r_id :
                       r_idx == 4'd8 ? r_id ^ w_xor :
                       r_idx == 4'd9 ? TRAILER : w_rdata;
  scurve_word_buffer u_buf (
    .i_clk(Clk),
    .i_we(w_store),
    .i_waddr(r_count),
    .i_wdata(bus.SCurve_Data),
    .i_raddr(3'(r_idx - 4'd2)),
    .o_rdata(w_rdata),
    .o_xor(w_xor)
  );
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      r_state <= COLLECT;
      r_count <= '0;
      r_idx <= '0;
      r_id <= '0;
      r_out <= '0;
      r_wr <= 1'b0;
      r_busy <= 1'b0;
      r_ovf <= 1'b0;
      r_cerr <= 1'b0;
    end else begin
      r_wr <= 1'b0;
      if (bus.SCurve_Data_wr_en && !w_store) r_ovf <= 1'b1;
      if (r_state == COLLECT) begin
        if (r_wr) r_busy <= 1'b0;
        if (w_store) r_count <= w_cnt_next;
        if (w_store && r_count == 3'd0) begin
          r_id <= {bus.Channel_Index, bus.DAC_Code};
          r_busy <= 1'b1;
        end
        if (bus.One_Channel_Done) begin
          if (w_cnt_next == 3'(N_WORDS)) begin
            r_state <= SEND;
            r_idx <= '0;
          end else begin
            r_cerr <= 1'b1;
            r_count <= '0;
            r_busy <= 1'b0;
          end
        end
      end else if (!bus.Out_Fifo_Full) begin
        r_wr <= 1'b1;
        r_out <= w_word;
        r_idx <= r_idx + 4'd1;
        if (r_idx == 4'(FRAME_LEN - 1)) begin
          r_state <= COLLECT;
          r_count <= '0;
        end
      end
    end
  end
  assign bus.Out_Data = r_out;
  assign bus.Out_Data_wr_en = r_wr;
  assign bus.Packer_Busy = r_busy;
  assign bus.Overflow_Err = r_ovf;
  assign bus.Count_Err = r_cerr;
endmodule

// File: tb/tb_scurve_frame_packer.sv
// tb_scurve_frame_packer: randomized self-checking bench comparing emitted frames against a frame-building reference model
module tb_scurve_frame_packer;
  import scurve_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int done_cyc = 0;
  logic [15:0] got_q[$];
  int got_c[$];
  logic [15:0] wds[8];
  logic [15:0] exp_f[10];
  scurve_frame_packer_if bus();
  scurve_frame_packer dut (.Clk(clk), .reset_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    if (bus.Out_Data_wr_en === 1'b1) begin
      got_q.push_back(bus.Out_Data);
      got_c.push_back(cyc);
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
    $fatal(1);
  end
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic clear_q;
    got_q.delete();
    got_c.delete();
  endtask
  task automatic rand_words(input int n);
    for (int i = 0; i < n; i++) wds[i] = 16'($urandom);
  endtask
  task automatic model(input logic [5:0] ch, input logic [9:0] dac);
    logic [15:0] id;
    logic [15:0] chk;
    id = {ch, dac};
    chk = id;
    exp_f[0] = HEADER;
    exp_f[1] = id;
    for (int i = 0; i < 6; i++) begin
      exp_f[i + 2] = wds[i];
      chk = chk ^ wds[i];
    end
    exp_f[8] = chk;
    exp_f[9] = TRAILER;
  endtask
  function automatic logic [159:0] got_frame(input int base);
    logic [159:0] r;
    for (int i = 0; i < 10; i++) r[159 - 16 * i -: 16] = (base + i < got_q.size()) ? got_q[base + i] : 16'hxxxx;
    return r;
  endfunction
  function automatic logic [159:0] exp_frame();
    logic [159:0] r;
    for (int i = 0; i < 10; i++) r[159 - 16 * i -: 16] = exp_f[i];
    return r;
  endfunction
  task automatic send(input logic [5:0] ch, input logic [9:0] dac, input int n, input int gap, input bit with_done);
    bus.Channel_Index = ch;
    bus.DAC_Code = dac;
    for (int i = 0; i < n; i++) begin
      bus.SCurve_Data = wds[i];
      bus.SCurve_Data_wr_en = 1'b1;
      if (with_done && i == n - 1) begin
        bus.One_Channel_Done = 1'b1;
        done_cyc = cyc;
      end
      tick;
      bus.SCurve_Data_wr_en = 1'b0;
      bus.One_Channel_Done = 1'b0;
      if (i < n - 1) repeat (gap - 1) tick;
    end
    if (!with_done) begin
      tick;
      bus.One_Channel_Done = 1'b1;
      done_cyc = cyc;
      tick;
      bus.One_Channel_Done = 1'b0;
    end
  endtask
  task automatic wait_writes(input int n, input bit bp);
    int t;
    bit bp_done;
    t = 0;
    bp_done = 0;
    while (got_q.size() < n && t < 200) begin
      if (bp && !bp_done && got_q.size() == 3) begin
        bus.Out_Fifo_Full = 1'b1;
        repeat (3) tick;
        bus.Out_Fifo_Full = 1'b0;
        bp_done = 1;
      end else begin
        tick;
        t++;
      end
    end
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick;
    nchk++; if (bus.Out_Data_wr_en !== 1'b0) begin nerr++; $display("FAIL reset_wr: got %b expected 0", bus.Out_Data_wr_en); end
    nchk++; if (bus.Out_Data !== 16'h0000) begin nerr++; $display("FAIL reset_data: got %h expected 0000", bus.Out_Data); end
    nchk++; if (bus.Packer_Busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b expected 0", bus.Packer_Busy); end
    nchk++; if (bus.Overflow_Err !== 1'b0) begin nerr++; $display("FAIL reset_ovf: got %b expected 0", bus.Overflow_Err); end
    nchk++; if (bus.Count_Err !== 1'b0) begin nerr++; $display("FAIL reset_cerr: got %b expected 0", bus.Count_Err); end
    rst_n = 1'b1;
    tick;
  endtask
  task automatic test_nominal;
    clear_q();
    for (int i = 0; i < 6; i++) wds[i] = 16'(i + 1);
    model(6'd5, 10'h1A3);
    bus.Channel_Index = 6'd5;
    bus.DAC_Code = 10'h1A3;
    nchk++; if (bus.Packer_Busy !== 1'b0) begin nerr++; $display("FAIL nom_busy_idle: got %b expected 0", bus.Packer_Busy); end
    bus.SCurve_Data = wds[0];
    bus.SCurve_Data_wr_en = 1'b1;
    tick;
    bus.SCurve_Data_wr_en = 1'b0;
    nchk++; if (bus.Packer_Busy !== 1'b1) begin nerr++; $display("FAIL nom_busy_rise: got %b expected 1", bus.Packer_Busy); end
    tick;
    for (int i = 1; i < 6; i++) begin
      bus.SCurve_Data = wds[i];
      bus.SCurve_Data_wr_en = 1'b1;
      tick;
      bus.SCurve_Data_wr_en = 1'b0;
      if (i < 5) tick;
    end
    tick;
    bus.One_Channel_Done = 1'b1;
    done_cyc = cyc;
    tick;
    bus.One_Channel_Done = 1'b0;
    wait_writes(10, 0);
    nchk++; if (got_q.size() != 10) begin nerr++; $display("FAIL nom_count: got %0d writes expected 10", got_q.size()); end
    nchk++; if (got_frame(0) !== exp_frame()) begin nerr++; $display("FAIL nom_frame: got %h expected %h", got_frame(0), exp_frame()); end
    nchk++; if (got_c.size() < 10 || got_c[0] != done_cyc + 2) begin nerr++; $display("FAIL nom_latency: got first write cycle %0d expected %0d", got_c.size() > 0 ? got_c[0] : -1, done_cyc + 2); end
    nchk++; if (got_c.size() < 10 || got_c[9] != got_c[0] + 9) begin nerr++; $display("FAIL nom_span: got %0d expected 9", got_c.size() >= 10 ? got_c[9] - got_c[0] : -1); end
    nchk++; if (bus.Packer_Busy !== 1'b1) begin nerr++; $display("FAIL nom_busy_trailer: got %b expected 1", bus.Packer_Busy); end
    tick;
    nchk++; if (bus.Packer_Busy !== 1'b0) begin nerr++; $display("FAIL nom_busy_fall: got %b expected 0", bus.Packer_Busy); end
    nchk++; if (bus.Overflow_Err !== 1'b0 || bus.Count_Err !== 1'b0) begin nerr++; $display("FAIL nom_flags: got ovf=%b cerr=%b expected 0 0", bus.Overflow_Err, bus.Count_Err); end
  endtask
  task automatic test_backpressure;
    logic [5:0] ch;
    logic [9:0] dac;
    clear_q();
    ch = 6'($urandom);
    dac = 10'($urandom);
    rand_words(6);
    model(ch, dac);
    send(ch, dac, 6, 2, 0);
    wait_writes(10, 1);
    repeat (5) tick;
    nchk++; if (got_q.size() != 10) begin nerr++; $display("FAIL bp_count: got %0d writes expected 10", got_q.size()); end
    nchk++; if (got_frame(0) !== exp_frame()) begin nerr++; $display("FAIL bp_frame: got %h expected %h", got_frame(0), exp_frame()); end
    nchk++; if (got_c.size() < 10 || got_c[9] - got_c[0] != 12) begin nerr++; $display("FAIL bp_span: got %0d expected 12", got_c.size() >= 10 ? got_c[9] - got_c[0] : -1); end
  endtask
  task automatic test_short;
    logic [5:0] ch;
    logic [9:0] dac;
    do_reset();
    clear_q();
    rand_words(4);
    send(6'($urandom), 10'($urandom), 4, 2, 0);
    nchk++; if (bus.Count_Err !== 1'b1) begin nerr++; $display("FAIL short_cerr: got %b expected 1", bus.Count_Err); end
    nchk++; if (bus.Packer_Busy !== 1'b0) begin nerr++; $display("FAIL short_busy: got %b expected 0", bus.Packer_Busy); end
    repeat (15) tick;
    nchk++; if (got_q.size() != 0) begin nerr++; $display("FAIL short_nowrite: got %0d writes expected 0", got_q.size()); end
    ch = 6'($urandom);
    dac = 10'($urandom);
    rand_words(6);
    model(ch, dac);
    send(ch, dac, 6, 2, 0);
    wait_writes(10, 0);
    nchk++; if (got_frame(0) !== exp_frame()) begin nerr++; $display("FAIL short_next_frame: got %h expected %h", got_frame(0), exp_frame()); end
    repeat (2) tick;
  endtask
  task automatic test_overflow;
    logic [5:0] ch;
    logic [9:0] dac;
    do_reset();
    clear_q();
    ch = 6'($urandom);
    dac = 10'($urandom);
    rand_words(7);
    model(ch, dac);
    send(ch, dac, 7, 2, 0);
    nchk++; if (bus.Overflow_Err !== 1'b1) begin nerr++; $display("FAIL ovf_flag: got %b expected 1", bus.Overflow_Err); end
    wait_writes(10, 0);
    nchk++; if (got_frame(0) !== exp_frame()) begin nerr++; $display("FAIL ovf_frame: got %h expected %h", got_frame(0), exp_frame()); end
    repeat (2) tick;
    do_reset();
    clear_q();
    ch = 6'($urandom);
    dac = 10'($urandom);
    rand_words(6);
    model(ch, dac);
    send(ch, dac, 6, 2, 0);
    nchk++; if (bus.Overflow_Err !== 1'b0) begin nerr++; $display("FAIL ovf_clean: got %b expected 0", bus.Overflow_Err); end
    tick;
    bus.SCurve_Data = 16'($urandom);
    bus.SCurve_Data_wr_en = 1'b1;
    tick;
    bus.SCurve_Data_wr_en = 1'b0;
    wait_writes(10, 0);
    nchk++; if (bus.Overflow_Err !== 1'b1) begin nerr++; $display("FAIL ovf_send_flag: got %b expected 1", bus.Overflow_Err); end
    nchk++; if (got_frame(0) !== exp_frame()) begin nerr++; $display("FAIL ovf_send_frame: got %h expected %h", got_frame(0), exp_frame()); end
    repeat (2) tick;
  endtask
  task automatic test_simul_done;
    logic [5:0] ch;
    logic [9:0] dac;
    do_reset();
    clear_q();
    ch = 6'($urandom);
    dac = 10'($urandom);
    rand_words(6);
    model(ch, dac);
    send(ch, dac, 6, 2, 1);
    wait_writes(10, 0);
    nchk++; if (bus.Count_Err !== 1'b0) begin nerr++; $display("FAIL simul_cerr: got %b expected 0", bus.Count_Err); end
    nchk++; if (got_frame(0) !== exp_frame()) begin nerr++; $display("FAIL simul_frame: got %h expected %h", got_frame(0), exp_frame()); end
    repeat (2) tick;
  endtask
  task automatic test_reset_mid;
    logic [5:0] ch;
    logic [9:0] dac;
    clear_q();
    rand_words(7);
    send(6'($urandom), 10'($urandom), 7, 2, 0);
    wait_writes(4, 0);
    rst_n = 1'b0;
    tick;
    nchk++; if (bus.Out_Data_wr_en !== 1'b0) begin nerr++; $display("FAIL mid_wr: got %b expected 0", bus.Out_Data_wr_en); end
    nchk++; if ({bus.Packer_Busy, bus.Overflow_Err, bus.Count_Err} !== 3'b000) begin nerr++; $display("FAIL mid_flags: got %b expected 000", {bus.Packer_Busy, bus.Overflow_Err, bus.Count_Err}); end
    rst_n = 1'b1;
    repeat (15) tick;
    nchk++; if (got_q.size() != 4) begin nerr++; $display("FAIL mid_stop: got %0d writes expected 4", got_q.size()); end
    clear_q();
    ch = 6'($urandom);
    dac = 10'($urandom);
    rand_words(6);
    model(ch, dac);
    send(ch, dac, 6, 2, 0);
    wait_writes(10, 0);
    nchk++; if (got_frame(0) !== exp_frame()) begin nerr++; $display("FAIL mid_next_frame: got %h expected %h", got_frame(0), exp_frame()); end
    repeat (2) tick;
  endtask
  task automatic test_back_to_back;
    logic [159:0] exp_a;
    logic [5:0] ch;
    logic [9:0] dac;
    int t;
    clear_q();
    ch = 6'($urandom);
    dac = 10'($urandom);
    rand_words(6);
    model(ch, dac);
    exp_a = exp_frame();
    send(ch, dac, 6, 1, 0);
    t = 0;
    while (bus.Packer_Busy === 1'b1 && t < 100) begin
      tick;
      t++;
    end
    ch = 6'($urandom);
    dac = 10'($urandom);
    rand_words(6);
    model(ch, dac);
    send(ch, dac, 6, 1, 0);
    wait_writes(20, 0);
    repeat (3) tick;
    nchk++; if (got_q.size() != 20) begin nerr++; $display("FAIL b2b_count: got %0d writes expected 20", got_q.size()); end
    nchk++; if (got_frame(0) !== exp_a) begin nerr++; $display("FAIL b2b_frame_a: got %h expected %h", got_frame(0), exp_a); end
    nchk++; if (got_frame(10) !== exp_frame()) begin nerr++; $display("FAIL b2b_frame_b: got %h expected %h", got_frame(10), exp_frame()); end
  endtask
  initial begin
    bus.SCurve_Data = '0;
    bus.SCurve_Data_wr_en = 1'b0;
    bus.One_Channel_Done = 1'b0;
    bus.Channel_Index = '0;
    bus.DAC_Code = '0;
    bus.Out_Fifo_Full = 1'b0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_short();
    test_overflow();
    test_simul_done();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
